// File: rtl/instruction_fetch_if.sv
// Bundle between the fetch unit and its PC, program memory and decoder.
// The o_instr_count member exists only when IF_COUNT_EN is defined.
interface instruction_fetch_if #(
  parameter int NBITS    = 11,
  parameter int NB_INSTR = 16
);
  logic                i_enable;
  logic [NBITS-1:0]    i_pc;
  logic [NBITS-1:0]    o_pc_next;
  logic                o_wr_pc;
  logic [NBITS-1:0]    o_mem_addr;
  logic                o_mem_rd;
  logic [NB_INSTR-1:0] i_mem_data;
  logic [NB_INSTR-1:0] o_instr;
  logic                o_instr_valid;
  logic                i_instr_ready;
  logic                o_halt;
`ifdef IF_COUNT_EN
  logic [15:0]         o_instr_count;
`endif

  // master: the fetch unit itself
  modport master (
    input  i_enable, i_pc, i_mem_data, i_instr_ready,
    output o_pc_next, o_wr_pc, o_mem_addr, o_mem_rd, o_instr, o_instr_valid, o_halt
`ifdef IF_COUNT_EN
    , output o_instr_count
`endif
  );

  // slave: PC, program memory and decoder seen as one environment
  modport slave (
    output i_enable, i_pc, i_mem_data, i_instr_ready,
    input  o_pc_next, o_wr_pc, o_mem_addr, o_mem_rd, o_instr, o_instr_valid, o_halt
`ifdef IF_COUNT_EN
    , input o_instr_count
`endif
  );
endinterface

// File: rtl/instruction_fetch.sv
// BIP instruction fetch: reads program memory at the PC, hands the word to the decoder
// over valid/ready, strobes the PC forward and stops on HLT. IF_COUNT_EN adds o_instr_count.
module instruction_fetch #(
  parameter int NBITS       = 11,
  parameter int NB_INSTR    = 16,
  parameter int NB_OPCODE   = 5,
  parameter int MEM_LATENCY = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  instruction_fetch_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_ADV,
    ST_HALT
  } state_t;

  localparam logic [NB_OPCODE-1:0] OP_HLT    = '0;
  localparam logic [1:0]           WAIT_LOAD = 2'(MEM_LATENCY - 1);

  state_t              state;
  logic [1:0]          wait_cnt;
  logic [NBITS-1:0]    addr_q;
  logic                mem_rd;
  logic                wr_pc;
  logic [NB_INSTR-1:0] instr;
  logic                instr_valid;
  logic                halt;

  // NOTE: every register, including the captured instruction, sits on the async reset so
  // a reset mid-fetch leaves no stale word behind.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      addr_q      <= '0;
      mem_rd      <= 1'b0;
      wr_pc       <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      halt        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_enable) begin
            state  <= ST_REQ;
            mem_rd <= 1'b1;
          end
        end
        ST_REQ: begin
          state    <= ST_WAIT;
          mem_rd   <= 1'b0;
          addr_q   <= bus.i_pc;
          wait_cnt <= WAIT_LOAD;
        end
        ST_WAIT: begin
          if (wait_cnt == 2'd0) begin
            state       <= ST_HOLD;
            instr       <= bus.i_mem_data;
            instr_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ST_HOLD: begin
          if (bus.i_instr_ready) begin
            instr_valid <= 1'b0;
            if (instr[NB_INSTR-1 -: NB_OPCODE] == OP_HLT) begin
              state <= ST_HALT;
              halt  <= 1'b1;
            end else begin
              state <= ST_ADV;
              wr_pc <= 1'b1;
            end
          end
        end
        ST_ADV: begin
          wr_pc <= 1'b0;
          if (bus.i_enable) begin
            state  <= ST_REQ;
            mem_rd <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: in REQ the address comes straight from i_pc so the read uses the PC as it is
  // now; afterwards the registered copy holds it regardless of later PC changes.
  assign bus.o_mem_addr    = (state == ST_REQ) ? bus.i_pc : addr_q;
  assign bus.o_pc_next     = bus.i_pc + NBITS'(1);
  assign bus.o_mem_rd      = mem_rd;
  assign bus.o_wr_pc       = wr_pc;
  assign bus.o_instr       = instr;
  assign bus.o_instr_valid = instr_valid;
  assign bus.o_halt        = halt;

`ifdef IF_COUNT_EN
  logic [15:0] instr_count;

  // counts accepted handshakes, HLT included, saturating at all-ones
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      instr_count <= '0;
    end else if (state == ST_HOLD && bus.i_instr_ready && instr_count != 16'hFFFF) begin
      instr_count <= instr_count + 16'd1;
    end
  end

  assign bus.o_instr_count = instr_count;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: two instances (MEM_LATENCY 1 and 3) share stimulus;
// the bench plays PC and program memory and checks against a transaction-level model.
module tb_instruction_fetch;

  logic clk;
  logic rst_n;
  logic enable;
  logic ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] mem [0:2047];

  // model state, index 0 = latency 1 instance, index 1 = latency 3 instance
  logic [10:0] pc        [2];
  logic [15:0] pipe      [2][4];
  bit          pend      [2];
  logic [10:0] pend_pc   [2];
  int          req_cyc   [2];
  bit          seen_valid[2];
  bit          h         [2];
  bit          adv_due   [2];
  bit          prev_hs   [2];
  bit          prev_hold [2];
  bit          prev_wr   [2];
  logic [15:0] prev_instr[2];
  int          acc_cnt   [2];
  bit          prev_en;

  // samples taken mid-cycle
  logic        s_rd   [2];
  logic        s_wr   [2];
  logic        s_valid[2];
  logic        s_halt [2];
  logic        s_hs   [2];
  logic [10:0] s_addr [2];
  logic [10:0] s_pcn  [2];
  logic [15:0] s_instr[2];
  logic        s_en;
`ifdef IF_COUNT_EN
  logic [15:0] s_cnt  [2];
`endif

  instruction_fetch_if #(.NBITS(11), .NB_INSTR(16)) bus1 ();
  instruction_fetch_if #(.NBITS(11), .NB_INSTR(16)) bus3 ();

  assign bus1.i_enable      = enable;
  assign bus3.i_enable      = enable;
  assign bus1.i_instr_ready = ready;
  assign bus3.i_instr_ready = ready;
  assign bus1.i_pc          = pc[0];
  assign bus3.i_pc          = pc[1];
  assign bus1.i_mem_data    = pipe[0][0];
  assign bus3.i_mem_data    = pipe[1][2];

  instruction_fetch #(.NBITS(11), .NB_INSTR(16), .NB_OPCODE(5), .MEM_LATENCY(1)) u_dut1 (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus1)
  );

  instruction_fetch #(.NBITS(11), .NB_INSTR(16), .NB_OPCODE(5), .MEM_LATENCY(3)) u_dut3 (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      pend[d]       = 1'b0;
      pend_pc[d]    = '0;
      req_cyc[d]    = 0;
      seen_valid[d] = 1'b0;
      h[d]          = 1'b0;
      adv_due[d]    = 1'b0;
      prev_hs[d]    = 1'b0;
      prev_hold[d]  = 1'b0;
      prev_wr[d]    = 1'b0;
      prev_instr[d] = '0;
      acc_cnt[d]    = 0;
      for (int k = 0; k < 4; k++) pipe[d][k] = 16'hDEAD;
    end
    prev_en = 1'b0;
  endtask

  task automatic sample();
    s_en       = enable;
    s_rd[0]    = bus1.o_mem_rd;       s_rd[1]    = bus3.o_mem_rd;
    s_wr[0]    = bus1.o_wr_pc;        s_wr[1]    = bus3.o_wr_pc;
    s_valid[0] = bus1.o_instr_valid;  s_valid[1] = bus3.o_instr_valid;
    s_halt[0]  = bus1.o_halt;         s_halt[1]  = bus3.o_halt;
    s_addr[0]  = bus1.o_mem_addr;     s_addr[1]  = bus3.o_mem_addr;
    s_pcn[0]   = bus1.o_pc_next;      s_pcn[1]   = bus3.o_pc_next;
    s_instr[0] = bus1.o_instr;        s_instr[1] = bus3.o_instr;
`ifdef IF_COUNT_EN
    s_cnt[0]   = bus1.o_instr_count;  s_cnt[1]   = bus3.o_instr_count;
`endif
    for (int d = 0; d < 2; d++) s_hs[d] = s_valid[d] && ready;
  endtask

  task automatic scoreboard();
    string p;
    int    lat;
    for (int d = 0; d < 2; d++) begin
      p   = (d == 0) ? "L1 " : "L3 ";
      lat = (d == 0) ? 1 : 3;
      check({p, "pc_next"}, 32'(s_pcn[d]), 32'((int'(pc[d]) + 1) % 2048));
      check({p, "halt"}, 32'(s_halt[d]), 32'(h[d]));
      check({p, "wr_pc"}, 32'(s_wr[d]), 32'(adv_due[d]));
`ifdef IF_COUNT_EN
      check({p, "count"}, 32'(s_cnt[d]), 32'(acc_cnt[d]));
`endif
      if (h[d]) check({p, "rd_halted"}, 32'(s_rd[d]), 32'd0);
      if (prev_wr[d] && prev_en) check({p, "rd_after_adv"}, 32'(s_rd[d]), 32'd1);
      if (s_rd[d]) begin
        check({p, "rd_busy"}, 32'(pend[d]), 32'd0);
        check({p, "rd_addr"}, 32'(s_addr[d]), 32'(pc[d]));
      end
      if (pend[d] && !s_rd[d]) check({p, "addr_hold"}, 32'(s_addr[d]), 32'(pend_pc[d]));
      if (s_valid[d] && !seen_valid[d]) begin
        check({p, "valid_unrequested"}, 32'(pend[d]), 32'd1);
        check({p, "latency"}, 32'(cyc - req_cyc[d]), 32'(lat + 1));
        check({p, "instr"}, 32'(s_instr[d]), 32'(mem[pend_pc[d]]));
      end
      if (prev_hold[d]) begin
        check({p, "hold_valid"}, 32'(s_valid[d]), 32'd1);
        check({p, "hold_instr"}, 32'(s_instr[d]), 32'(prev_instr[d]));
      end
      if (prev_hs[d]) check({p, "valid_drop"}, 32'(s_valid[d]), 32'd0);
    end
  endtask

  task automatic advance();
    bit hlt;
    for (int d = 0; d < 2; d++) begin
      for (int k = 3; k > 0; k--) pipe[d][k] = pipe[d][k-1];
      pipe[d][0] = s_rd[d] ? mem[s_addr[d]] : 16'hDEAD;
      hlt = (mem[pend_pc[d]][15:11] == 5'd0);
      adv_due[d]    = s_hs[d] && !hlt;
      if (s_hs[d] && hlt) h[d] = 1'b1;
      if (s_hs[d]) acc_cnt[d]++;
      prev_wr[d]    = s_wr[d];
      prev_hs[d]    = s_hs[d];
      prev_hold[d]  = s_valid[d] && !s_hs[d];
      prev_instr[d] = s_instr[d];
      if (s_valid[d]) seen_valid[d] = 1'b1;
      if (s_hs[d]) pend[d] = 1'b0;
      if (s_rd[d]) begin
        pend[d]       = 1'b1;
        pend_pc[d]    = pc[d];
        req_cyc[d]    = cyc;
        seen_valid[d] = 1'b0;
      end
      if (s_wr[d]) pc[d] = pc[d] + 11'd1;
    end
    prev_en = s_en;
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    scoreboard();
    @(posedge clk);
    #1;
    advance();
  endtask

  task automatic drain();
    enable = 1'b0;
    ready  = 1'b1;
    repeat (10) cycle();
  endtask

  task automatic wait_req(input int d, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle();
      found = s_rd[d];
    end
    check({tag, "_req_seen"}, 32'(found), 32'd1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_L1_rd"},    32'(bus1.o_mem_rd),      32'd0);
    check({tag, "_L1_wr"},    32'(bus1.o_wr_pc),       32'd0);
    check({tag, "_L1_valid"}, 32'(bus1.o_instr_valid), 32'd0);
    check({tag, "_L1_halt"},  32'(bus1.o_halt),        32'd0);
    check({tag, "_L1_instr"}, 32'(bus1.o_instr),       32'd0);
    check({tag, "_L1_addr"},  32'(bus1.o_mem_addr),    32'd0);
    check({tag, "_L3_rd"},    32'(bus3.o_mem_rd),      32'd0);
    check({tag, "_L3_valid"}, 32'(bus3.o_instr_valid), 32'd0);
    check({tag, "_L3_instr"}, 32'(bus3.o_instr),       32'd0);
    check({tag, "_L3_addr"},  32'(bus3.o_mem_addr),    32'd0);
  endtask

  initial begin
    logic [15:0] held;
    int          wr_seen;
    int          k;
    bit          got;

    rst_n  = 1'b0;
    enable = 1'b0;
    ready  = 1'b0;
    pc[0]  = '0;
    pc[1]  = '0;
    reset_model();
    for (int a = 0; a < 2048; a++) begin
      mem[a] = 16'($urandom);
      if (mem[a][15:11] == 5'd0) mem[a][15] = 1'b1;
    end

    // reset state
    #3;
    check_cleared("reset");
    check("reset_pc_next", 32'(bus1.o_pc_next), 32'd1);
    #8;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // idle with enable low
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("idle_rd",    32'(s_rd[0] | s_rd[1]),       32'd0);
      check("idle_wr",    32'(s_wr[0] | s_wr[1]),       32'd0);
      check("idle_valid", 32'(s_valid[0] | s_valid[1]), 32'd0);
    end

    // PC wrap
    pc[0] = 11'd2047;
    pc[1] = 11'd2047;
    #1;
    check("wrap_L1", 32'(bus1.o_pc_next), 32'd0);
    check("wrap_L3", 32'(bus3.o_pc_next), 32'd0);
    cycle();

    // basic fetch at latency 1
    drain();
    pc[0]  = 11'd5;
    pc[1]  = 11'd5;
    mem[5] = 16'h0803;
    ready  = 1'b1;
    enable = 1'b1;
    wait_req(0, "basic");
    check("basic_addr", 32'(s_addr[0]), 32'd5);
    cycle();
    check("basic_wait_valid", 32'(s_valid[0]), 32'd0);
    cycle();
    check("basic_valid", 32'(s_valid[0]), 32'd1);
    check("basic_instr", 32'(s_instr[0]), 32'h0803);
    cycle();
    check("basic_wr", 32'(s_wr[0]), 32'd1);
    cycle();
    check("basic_next_req", 32'(s_rd[0]), 32'd1);
    check("basic_next_addr", 32'(s_addr[0]), 32'd6);

    // backpressure, with a PC change mid-fetch
    drain();
    pc[0]  = 11'd40;
    pc[1]  = 11'd40;
    ready  = 1'b0;
    enable = 1'b1;
    got    = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      cycle();
      got = s_valid[0];
    end
    check("bp_valid_seen", 32'(got), 32'd1);
    held    = s_instr[0];
    pc[0]   = pc[0] + 11'd37;
    pc[1]   = pc[1] + 11'd37;
    wr_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("bp_valid", 32'(s_valid[0]), 32'd1);
      check("bp_instr", 32'(s_instr[0]), 32'(held));
      check("bp_addr",  32'(s_addr[0]),  32'd40);
      wr_seen += int'(s_wr[0]);
    end
    check("bp_no_wr_in_hold", 32'(wr_seen), 32'd0);
    enable = 1'b0;
    ready  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      wr_seen += int'(s_wr[0]);
    end
    check("bp_wr_pulses", 32'(wr_seen), 32'd1);

    // randomized enable / ready
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      ready  = ($urandom_range(0, 2) != 0);
      cycle();
    end

    // async reset while in WAIT, then restart at REQ; latency-3 valid at n+4
    drain();
    pc[0]  = 11'd100;
    pc[1]  = 11'd100;
    enable = 1'b1;
    wait_req(0, "mid");
    #1;
    rst_n = 1'b0;
    #1;
    check_cleared("mid_reset");
    reset_model();
    cycle();
    rst_n = 1'b1;
    wait_req(1, "restart");
    check("restart_addr", 32'(s_addr[1]), 32'd100);
    k   = 0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      k++;
      got = s_valid[1];
    end
    check("l3_valid_at_n4", 32'(k), 32'd4);

    // HLT
    drain();
    pc[0]    = 11'd300;
    pc[1]    = 11'd300;
    mem[300] = 16'h0000;
    ready    = 1'b1;
    enable   = 1'b1;
    got      = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle();
      got = s_halt[0] && s_halt[1];
    end
    check("hlt_reached", 32'(got), 32'd1);
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("hlt_rd",   32'(s_rd[0] | s_rd[1]),   32'd0);
      check("hlt_wr",   32'(s_wr[0] | s_wr[1]),   32'd0);
      check("hlt_flag", 32'(s_halt[0] & s_halt[1]), 32'd1);
    end
    check("hlt_pc_L1", 32'(pc[0]), 32'd300);
    check("hlt_pc_L3", 32'(pc[1]), 32'd300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
